// File: rtl/adder_pkg.sv
// Shared sizing helpers for the pipelined add/subtract unit.
package adder_pkg;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle between the source, the adder and the sink.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/adder_chunk.sv
// Combinational W-bit slice of the carry chain: {co, s} = a + b + ci.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit whose carry chain is cut into STAGES registered chunks,
// with a valid/ready handshake on both sides and one op per cycle throughput.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           reset,
  pipelined_adder_if.slave bus
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             msb_carry_in;

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  assign advance      = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;

  // Stage k sees the operand bits not yet consumed (a_cur/b_cur, low chunk first)
  // and all finished sum chunks below it; done_cur adds this stage's chunk on top.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k * CHUNK;

    logic [REM-1:0]         a_cur;
    logic [REM-1:0]         b_cur;
    logic                   carry_cur;
    logic                   valid_cur;
    logic [CHUNK-1:0]       s;
    logic                   co;
    logic [(k+1)*CHUNK-1:0] done_cur;

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a  (a_cur[CHUNK-1:0]),
      .b  (b_cur[CHUNK-1:0]),
      .ci (carry_cur),
      .s  (s),
      .co (co)
    );

    if (k == 0) begin : g_src
      assign a_cur     = bus.a;
      assign b_cur     = b_eff;
      assign carry_cur = bus.sub | bus.cin;
      assign valid_cur = bus.in_valid;
      assign done_cur  = s;
    end else begin : g_src
      logic [REM-1:0]     a_q;
      logic [REM-1:0]     b_q;
      logic               carry_q;
      logic               valid_q;
      logic [k*CHUNK-1:0] lo_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q <= 1'b0;
        end else if (advance) begin
          valid_q <= g_stage[k-1].valid_cur;
        end
        if (advance) begin
          a_q     <= g_stage[k-1].a_cur[REM+CHUNK-1:CHUNK];
          b_q     <= g_stage[k-1].b_cur[REM+CHUNK-1:CHUNK];
          carry_q <= g_stage[k-1].co;
          lo_q    <= g_stage[k-1].done_cur;
        end
      end

      assign a_cur     = a_q;
      assign b_cur     = b_q;
      assign carry_cur = carry_q;
      assign valid_cur = valid_q;
      assign done_cur  = {s, lo_q};
    end
  end

  // Carry into the MSB is recovered from the top bit's inputs and its sum bit.
  assign msb_carry_in = g_stage[LAST].a_cur[CHUNK-1] ^ g_stage[LAST].b_cur[CHUNK-1]
                      ^ g_stage[LAST].s[CHUNK-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.ovf       <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= g_stage[LAST].valid_cur;
      bus.sum       <= g_stage[LAST].done_cur;
      bus.cout      <= g_stage[LAST].co;
      bus.ovf       <= msb_carry_in ^ g_stage[LAST].co;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised checks of pipelined_adder: main 32x4 instance plus
// three parameter-sweep instances running alongside it.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sweep_rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder_if #(.WIDTH(32)) mbus ();

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk   (clk),
    .reset (rst),
    .bus   (mbus)
  );

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {ovf, cout, sum} for a w-bit unit, built from the textbook
  // overflow rule (same-signed operands giving a differently signed result).
  function automatic logic [65:0] refAdd(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub);
    logic [63:0] mask, am, bm, sm;
    logic [64:0] full;
    logic c, v;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (sub ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bm} + {64'd0, sub | cin};
    sm   = full[63:0] & mask;
    c    = full[w];
    v    = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
    return {v, c, sm};
  endfunction

  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub, input logic [31:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
    int lat;
    @(negedge clk);
    mbus.a = a;
    mbus.b = b;
    mbus.cin = cin;
    mbus.sub = sub;
    mbus.in_valid = 1'b1;
    mbus.out_ready = 1'b1;
    #1;
    checkOutput({tag, " in_ready"}, mbus.in_ready, 1);
    @(negedge clk);
    mbus.in_valid = 1'b0;
    lat = 1;
    while (!mbus.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, lat, 4);
    checkOutput({tag, " sum"}, mbus.sum, exp_sum);
    checkOutput({tag, " cout"}, mbus.cout, exp_cout);
    checkOutput({tag, " ovf"}, mbus.ovf, exp_ovf);
  endtask

  task automatic runBackpressure();
    logic [65:0] expq[$];
    logic [65:0] exp;
    logic [33:0] held;
    logic [31:0] ra, rb;
    logic rc, rs;
    int sent, recv, budget;
    bit have_op, stalled;
    sent = 0; recv = 0; budget = 0; have_op = 0; stalled = 0; held = '0;
    ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
    while (recv < 20 && budget < 400) begin
      @(negedge clk);
      budget++;
      if (stalled)
        checkOutput("stall hold", {mbus.out_valid, mbus.cout, mbus.ovf, mbus.sum}, {1'b1, held});
      mbus.out_ready = 1'($urandom_range(0, 1));
      if (sent < 20 && !have_op) begin
        ra = $urandom();
        rb = $urandom();
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        have_op = 1;
      end
      mbus.in_valid = have_op;
      mbus.a = ra;
      mbus.b = rb;
      mbus.cin = rc;
      mbus.sub = rs;
      #1;
      if (mbus.out_valid && !mbus.out_ready)
        checkOutput("in_ready while stalled", mbus.in_ready, 0);
      if (mbus.out_valid && mbus.out_ready) begin
        checkOutput("stream result pending", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          exp = expq.pop_front();
          checkOutput("stream result", {6'b0, mbus.ovf, mbus.cout, 32'b0, mbus.sum}, {6'b0, exp});
          recv++;
        end
      end
      stalled = mbus.out_valid && !mbus.out_ready;
      held = {mbus.cout, mbus.ovf, mbus.sum};
      if (mbus.in_valid && mbus.in_ready) begin
        expq.push_back(refAdd(32, {32'b0, ra}, {32'b0, rb}, rc, rs));
        sent++;
        have_op = 0;
      end
    end
    mbus.in_valid = 1'b0;
    mbus.out_ready = 1'b1;
    checkOutput("stream count", recv, 20);
  endtask

  task automatic runMidReset();
    int stale;
    mbus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mbus.in_valid = 1'b1;
      mbus.a = 32'(100 + i);
      mbus.b = 32'(7 * i + 1);
      mbus.cin = 1'b0;
      mbus.sub = 1'b0;
    end
    @(negedge clk);
    mbus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset out_valid", mbus.out_valid, 0);
    checkOutput("mid reset sum", mbus.sum, 0);
    checkOutput("mid reset in_ready", mbus.in_ready, 1);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mbus.out_valid) stale++;
    end
    checkOutput("stale results after reset", stale, 0);
    applyStimulus("post reset add", 32'h0000_1234, 32'h0000_0F0F, 1'b1, 1'b0,
                  32'h0000_2144, 1'b0, 1'b0);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 4 : (g == 1) ? 8 : 64;
    localparam int SS = (g == 0) ? 1 : (g == 1) ? 8 : 4;
    bit done = 0;

    pipelined_adder_if #(.WIDTH(SW)) sif ();

    pipelined_adder #(.WIDTH(SW), .STAGES(SS)) u_dut (
      .clk   (clk),
      .reset (sweep_rst),
      .bus   (sif)
    );

    initial begin
      logic [65:0] expq[$];
      int cycq[$];
      logic [65:0] exp;
      logic [63:0] ra, rb;
      logic rc, rs;
      int sent, budget;
      sent = 0;
      budget = 0;
      sif.in_valid = 1'b0;
      sif.a = '0;
      sif.b = '0;
      sif.cin = 1'b0;
      sif.sub = 1'b0;
      sif.out_ready = 1'b1;
      while (sweep_rst) @(negedge clk);
      while ((sent < 1000 || expq.size() != 0) && budget < 6000) begin
        @(negedge clk);
        budget++;
        if (sif.out_valid) begin
          checkOutput($sformatf("sweep W%0d S%0d pending", SW, SS), expq.size() != 0, 1);
          if (expq.size() != 0) begin
            exp = expq.pop_front();
            checkOutput($sformatf("sweep W%0d S%0d result", SW, SS),
                        {6'b0, sif.ovf, sif.cout, 64'(sif.sum)}, {6'b0, exp});
            checkOutput($sformatf("sweep W%0d S%0d latency", SW, SS), cyc - cycq.pop_front(), SS);
          end
        end
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          ra = {$urandom(), $urandom()};
          rb = {$urandom(), $urandom()};
          rc = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          sif.in_valid = 1'b1;
          sif.a = ra[SW-1:0];
          sif.b = rb[SW-1:0];
          sif.cin = rc;
          sif.sub = rs;
          expq.push_back(refAdd(SW, ra, rb, rc, rs));
          cycq.push_back(cyc);
          sent++;
        end else begin
          sif.in_valid = 1'b0;
        end
      end
      sif.in_valid = 1'b0;
      checkOutput($sformatf("sweep W%0d S%0d sent", SW, SS), sent, 1000);
      checkOutput($sformatf("sweep W%0d S%0d drained", SW, SS), expq.size(), 0);
      done = 1;
    end
  end

  initial begin
    sweep_rst = 1'b1;
    repeat (2) @(negedge clk);
    sweep_rst = 1'b0;
  end

  initial begin
    int budget;
    rst = 1'b1;
    mbus.in_valid = 1'b0;
    mbus.a = '0;
    mbus.b = '0;
    mbus.cin = 1'b0;
    mbus.sub = 1'b0;
    mbus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", mbus.out_valid, 0);
    checkOutput("reset sum", mbus.sum, 0);
    checkOutput("reset cout", mbus.cout, 0);
    checkOutput("reset ovf", mbus.ovf, 0);
    checkOutput("reset in_ready", mbus.in_ready, 1);
    rst = 1'b0;

    applyStimulus("add wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus("sub borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    applyStimulus("sub ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    applyStimulus("add ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    applyStimulus("sub ignores cin", 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    applyStimulus("add with cin", 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0101, 1'b0, 1'b0);
    applyStimulus("neg plus neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    runBackpressure();
    runMidReset();

    budget = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("sweeps finished", {g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
